// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: word sizes, control-bundle layout and the
// state encoding of the elastic boundary register.
package pipe_pkg;

    localparam int WORD_LEN        = 32;
    localparam int INSTRUCTION_LEN = 32;

    // Control bundle layout; every stage packs and unpacks through these offsets.
    localparam int CTRL_LEN        = 10;
    localparam int CTRL_MEM_WE_BIT = 0;
    localparam int CTRL_MEM_RE_BIT = 1;
    localparam int CTRL_RF_WE_BIT  = 2;
    localparam int CTRL_WB_SEL_LSB = 3;
    localparam int CTRL_WB_SEL_W   = 2;
    localparam int CTRL_ALU_OP_LSB = 5;
    localparam int CTRL_ALU_OP_W   = 5;

    // Bubble: every enable inactive.
    localparam logic [CTRL_LEN-1:0] CTRL_NOP = 10'b00_0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_e;

    function automatic skid_state_e skid_state(input logic main_v, input logic skid_v);
        case ({skid_v, main_v})
            2'b01:   return ST_ONE;
            2'b11:   return ST_FULL;
            default: return ST_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the performance
// counters of the pipeline.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step until all ones and stick there.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline boundary register: main entry drives the outputs, a skid
// entry absorbs the one extra beat that arrives while in_ready is registered.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int CTRL_W      = 10,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [CTRL_W-1:0] NOP_C = CTRL_W'(CTRL_NOP);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic              in_ready_q,   in_ready_d;

    logic        acc_s;
    logic        pop_s;
    skid_state_e state_s;

    assign acc_s   = in_valid & in_ready_q;
    assign pop_s   = main_valid_q & out_ready;
    assign state_s = skid_state(main_valid_q, skid_valid_q);

    // Next-state of both entries; any path that empties main also zeroes its ctrl.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_ctrl_d  = NOP_C;
            skid_ctrl_d  = NOP_C;
        end else begin
            case (state_s)
                ST_EMPTY: begin
                    if (acc_s) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                        main_ctrl_d  = in_ctrl;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end
                ST_ONE: begin
                    case ({acc_s, pop_s})
                        2'b11: begin
                            main_data_d = in_data;
                            main_ctrl_d = in_ctrl;
                        end
                        2'b10: begin
                            skid_valid_d = 1'b1;
                            skid_data_d  = in_data;
                            skid_ctrl_d  = in_ctrl;
                        end
                        2'b01: begin
                            main_valid_d = 1'b0;
                            main_ctrl_d  = NOP_C;
                        end
                        default: begin
                            main_valid_d = 1'b1;
                        end
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can move state.
                    if (pop_s) begin
                        main_data_d  = skid_data_q;
                        main_ctrl_d  = skid_ctrl_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        skid_valid_d = 1'b1;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                    main_ctrl_d  = NOP_C;
                    skid_ctrl_d  = NOP_C;
                end
            endcase
        end
        in_ready_d = ~skid_valid_d;
    end

    // Entry registers and the registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= {DATA_W{1'b0}};
            main_ctrl_q  <= NOP_C;
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DATA_W{1'b0}};
            skid_ctrl_q  <= NOP_C;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            in_ready_q   <= in_ready_d;
        end
    end

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (main_valid_q & ~out_ready),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a default-width instance and a 4-bit
// stall-counter instance driven by the same stimulus.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [9:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready,  in_ready4;
    logic        out_valid, out_valid4;
    logic [63:0] out_data,  out_data4;
    logic [9:0]  out_ctrl,  out_ctrl4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_ctrl(out_ctrl4),
        .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sit 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [9:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 64'h0, 10'h0);
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_ctrl",  {54'd0, out_ctrl},  64'd0);
        chk("rst_out_data",  out_data,           64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_stall",     {48'd0, stall_cnt}, 64'd0);
        step(); step();
        rst = 1'b0;

        // Single transfer through an empty stage.
        out_ready = 1'b1;
        drive(1'b1, 64'h1234, 10'h3FF);
        step();
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_out_data",  out_data,           64'h1234);
        chk("t1_out_ctrl",  {54'd0, out_ctrl},  64'h3FF);
        chk("t1_in_ready",  {63'd0, in_ready},  64'd1);
        drive(1'b0, 64'h0, 10'h0);
        step();
        chk("t1_bubble_valid", {63'd0, out_valid}, 64'd0);
        chk("t1_bubble_ctrl",  {54'd0, out_ctrl},  64'd0);

        // Back-to-back stream 1..8.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 10'(i));
            step();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_data",  out_data,           64'(i));
        end
        drive(1'b0, 64'h0, 10'h0);
        step();
        chk("stream_end_valid", {63'd0, out_valid}, 64'd0);
        chk("stream_stall",     {48'd0, stall_cnt}, 64'd0);

        // Back-pressure fills main then skid.
        out_ready = 1'b0;
        drive(1'b1, 64'd5, 10'd5);
        step();
        chk("bp_a_ready", {63'd0, in_ready},  64'd1);
        chk("bp_a_stall", {48'd0, stall_cnt}, 64'd0);
        drive(1'b1, 64'd6, 10'd6);
        step();
        chk("bp_full_ready", {63'd0, in_ready},  64'd0);
        chk("bp_full_data",  out_data,           64'd5);
        chk("bp_full_stall", {48'd0, stall_cnt}, 64'd1);
        drive(1'b1, 64'd7, 10'd7);
        step();
        chk("bp_hold_data",  out_data,           64'd5);
        chk("bp_hold_ready", {63'd0, in_ready},  64'd0);
        chk("bp_hold_stall", {48'd0, stall_cnt}, 64'd2);
        drive(1'b0, 64'h0, 10'h0);
        out_ready = 1'b1;
        step();
        chk("bp_pop_a_data",  out_data,           64'd6);
        chk("bp_pop_a_ctrl",  {54'd0, out_ctrl},  64'd6);
        chk("bp_pop_a_ready", {63'd0, in_ready},  64'd1);
        chk("bp_pop_a_stall", {48'd0, stall_cnt}, 64'd2);
        step();
        chk("bp_pop_b_valid", {63'd0, out_valid}, 64'd0);

        // Flush while FULL with an offered input.
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 10'h11);
        step();
        drive(1'b1, 64'h12, 10'h12);
        step();
        chk("fl_full_ready", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        drive(1'b1, 64'd9, 10'd9);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 10'h0);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ctrl",  {54'd0, out_ctrl},  64'd0);
        chk("fl_ready", {63'd0, in_ready},  64'd1);
        chk("fl_data_kept", out_data, 64'h11);
        chk("fl_stall", {48'd0, stall_cnt}, 64'd4);
        out_ready = 1'b1;
        step();
        chk("fl_no_resurrect", {63'd0, out_valid}, 64'd0);

        // Flush in ONE with a simultaneous accept and pop.
        drive(1'b1, 64'h21, 10'h21);
        step();
        chk("fl1_data", out_data, 64'h21);
        flush = 1'b1;
        drive(1'b1, 64'h22, 10'h22);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 10'h0);
        chk("fl1_valid", {63'd0, out_valid}, 64'd0);
        chk("fl1_ctrl",  {54'd0, out_ctrl},  64'd0);
        chk("fl1_ready", {63'd0, in_ready},  64'd1);
        step();
        chk("fl1_dropped", {63'd0, out_valid}, 64'd0);

        // Long stall: 16-bit counter keeps counting, 4-bit one sticks at 15.
        out_ready = 1'b0;
        drive(1'b1, 64'h31, 10'h31);
        step();
        drive(1'b0, 64'h0, 10'h0);
        chk("sat_start4", {60'd0, stall_cnt4}, 64'd4);
        for (int k = 0; k < 20; k++) step();
        chk("sat_cnt16", {48'd0, stall_cnt},  64'd24);
        chk("sat_cnt4",  {60'd0, stall_cnt4}, 64'd15);

        // Asynchronous reset mid-cycle while FULL.
        drive(1'b1, 64'h32, 10'h32);
        step();
        drive(1'b0, 64'h0, 10'h0);
        chk("ar_full_ready", {63'd0, in_ready},  64'd0);
        chk("ar_pre_stall",  {48'd0, stall_cnt}, 64'd25);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_ctrl",  {54'd0, out_ctrl},  64'd0);
        chk("ar_data",  out_data,           64'd0);
        chk("ar_stall", {48'd0, stall_cnt}, 64'd0);
        chk("ar_stall4", {60'd0, stall_cnt4}, 64'd0);
        chk("ar_ready", {63'd0, in_ready},  64'd1);
        step();
        rst = 1'b0;

        // Stage is usable again after reset.
        out_ready = 1'b1;
        drive(1'b1, 64'h55, 10'h2A);
        step();
        drive(1'b0, 64'h0, 10'h0);
        chk("post_valid", {63'd0, out_valid}, 64'd1);
        chk("post_data",  out_data,           64'h55);
        chk("post_ctrl",  {54'd0, out_ctrl},  64'h2A);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
